// File: rtl/frame_memory_arbiter.sv
// frame_memory_arbiter: shares the single frame-buffer memory port between the
// draw-write requester (req 0), the redraw/slot-fetch requester (req 1) and a
// built-in whole-memory clear engine. Memory-side outputs are registered; read
// results come back on a shared bus tagged with the requester that issued them.
module frame_memory_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned DATA_WIDTH   = 9,
  parameter int unsigned MEM_DEPTH    = 76800,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iClearReq,
  input  logic [DATA_WIDTH-1:0] iClearColour,
  output logic                  oClearBusy,
  input  logic                  iReq0,
  input  logic                  iReq1,
  input  logic                  iWe0,
  input  logic                  iWe1,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData0,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oGnt0,
  output logic                  oGnt1,
  output logic                  oRdValid0,
  output logic                  oRdValid1,
  output logic [DATA_WIDTH-1:0] oRdData,
  output logic [ADDR_WIDTH-1:0] oAddress,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oWren,
  output logic                  oChipSelect,
  input  logic [DATA_WIDTH-1:0] iQ
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    rr_q;       // 1: req 1 wins the next contention
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   cnt_d;
  logic [DATA_WIDTH-1:0]   colour_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    wren_q;
  logic                    cs_q;

  // Read-tag pipeline: stage 0 is loaded at grant time, stage READ_LATENCY
  // lines up with the cycle in which iQ carries that read's data.
  logic [READ_LATENCY:0]   tvld_q;
  logic [READ_LATENCY:0]   tid_q;
  logic [READ_LATENCY:0]   toor_q;

  logic                    can_grant;
  logic                    gnt0;
  logic                    gnt1;
  logic                    gnt_any;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_we;
  logic                    sel_in_range;
  logic                    rd_issue;
  logic                    rd_out;

  // Grant decision and selection of the winning request.
  always_comb begin
    can_grant    = (state_q == ST_IDLE) && !iClearReq && !iReset;
    gnt0         = can_grant && iReq0 && (!iReq1 || !rr_q);
    gnt1         = can_grant && iReq1 && (!iReq0 || rr_q);
    gnt_any      = gnt0 || gnt1;
    sel_addr     = gnt1 ? iAddr1 : iAddr0;
    sel_data     = gnt1 ? iData1 : iData0;
    sel_we       = gnt1 ? iWe1 : iWe0;
    sel_in_range = (sel_addr <= LAST_ADDR);
    rd_issue     = gnt_any && !sel_we;
    cnt_d        = (cnt_q == LAST_ADDR) ? cnt_q : cnt_q + 1'b1;
  end

  // Arbiter/clear FSM together with the registered memory-side outputs.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      colour_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      cs_q     <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      cs_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iClearReq) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            colour_q <= iClearColour;
          end else if (gnt_any) begin
            rr_q   <= gnt0;
            addr_q <= sel_addr;
            data_q <= sel_data;
            wren_q <= sel_we && sel_in_range;
            cs_q   <= sel_in_range;
          end
        end
        ST_CLEAR: begin
          addr_q <= cnt_q;
          data_q <= colour_q;
          wren_q <= 1'b1;
          cs_q   <= 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
          end
          cnt_q <= cnt_d;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Shift read tags towards the return slot; reset discards reads in flight.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      tvld_q <= '0;
      tid_q  <= '0;
      toor_q <= '0;
    end else begin
      tvld_q <= {tvld_q[READ_LATENCY-1:0], rd_issue};
      tid_q  <= {tid_q[READ_LATENCY-1:0], gnt1};
      toor_q <= {toor_q[READ_LATENCY-1:0], !sel_in_range};
    end
  end

  assign rd_out      = tvld_q[READ_LATENCY] && !iReset;
  assign oRdValid0   = rd_out && !tid_q[READ_LATENCY];
  assign oRdValid1   = rd_out && tid_q[READ_LATENCY];
  assign oRdData     = (rd_out && !toor_q[READ_LATENCY]) ? iQ : '0;

  assign oGnt0       = gnt0;
  assign oGnt1       = gnt1;
  assign oClearBusy  = (state_q == ST_CLEAR);
  assign oAddress    = addr_q;
  assign oData       = data_q;
  assign oWren       = wren_q;
  assign oChipSelect = cs_q;

endmodule

// File: tb/tb_frame_memory_arbiter.sv
// Bench for frame_memory_arbiter: memory stub with READ_LATENCY, a cycle-level
// reference model (queue of pending read returns, shadow memory), a vector
// table for arbitration and directed sequences for the multi-cycle cases.
module tb_frame_memory_arbiter;
  localparam int AW = 17;
  localparam int DW = 9;
  localparam int MD = 76800;
  localparam int RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clr_req, busy;
  logic [DW-1:0] clr_col;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          g0, g1, rv0, rv1;
  logic [DW-1:0] rdata, odata, q;
  logic [AW-1:0] oaddr;
  logic          wren, cs;

  frame_memory_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(MD), .READ_LATENCY(RL)
  ) dut (
    .iClk(clk), .iReset(rst), .iClearReq(clr_req), .iClearColour(clr_col),
    .oClearBusy(busy), .iReq0(req0), .iReq1(req1), .iWe0(we0), .iWe1(we1),
    .iAddr0(a0), .iAddr1(a1), .iData0(d0), .iData1(d1), .oGnt0(g0), .oGnt1(g1),
    .oRdValid0(rv0), .oRdValid1(rv1), .oRdData(rdata), .oAddress(oaddr),
    .oData(odata), .oWren(wren), .oChipSelect(cs), .iQ(q)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- memory stub ----------------
  logic [DW-1:0] mem [MD];
  logic [DW-1:0] qpipe [RL];
  logic [DW-1:0] rdv;
  assign q = qpipe[RL-1];

  initial begin
    for (int i = 0; i < MD; i++) mem[i] = '0;
    for (int i = 0; i < RL; i++) qpipe[i] = '0;
    forever begin
      @(posedge clk);
      rdv = DW'($urandom);
      if (cs === 1'b1 && int'(oaddr) < MD) begin
        if (wren) mem[oaddr] = odata;
        else rdv = mem[oaddr];
      end
      for (int i = RL - 1; i > 0; i--) qpipe[i] = qpipe[i-1];
      qpipe[0] = rdv;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } rd_t;
  rd_t sb[$];

  logic [DW-1:0] shadow [MD];
  bit            m_init = 0, m_busy = 0, m_fav = 0;
  int            m_left = 0, m_caddr = 0;
  logic [DW-1:0] m_col = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  bit            e_wren = 0, e_cs = 0;
  bit            xv0, xv1, eg0, eg1, sw, inr;
  logic [DW-1:0] xd, sd;
  logic [AW-1:0] sa;

  initial begin
    for (int i = 0; i < MD; i++) shadow[i] = '0;
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("m_busy", busy, m_busy);
        chk("m_addr", oaddr, e_addr);
        chk("m_data", odata, e_data);
        chk("m_wren", wren, e_wren);
        chk("m_cs", cs, e_cs);
      end
      if (rst) begin
        chk("m_rst_gnt0", g0, 0);
        chk("m_rst_gnt1", g1, 0);
        chk("m_rst_rv0", rv0, 0);
        chk("m_rst_rv1", rv1, 0);
        m_init = 1; m_busy = 0; m_fav = 0; m_left = 0; m_caddr = 0;
        e_addr = '0; e_data = '0; e_wren = 0; e_cs = 0;
        sb.delete();
      end else if (m_init) begin
        xv0 = 0; xv1 = 0; xd = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
          if (sb[0].id) xv1 = 1; else xv0 = 1;
          xd = sb[0].data;
          void'(sb.pop_front());
        end
        chk("m_rv0", rv0, xv0);
        chk("m_rv1", rv1, xv1);
        if (xv0 || xv1) chk("m_rdata", rdata, xd);
        eg0 = 0; eg1 = 0;
        if (!m_busy && !clr_req) begin
          if (req0 && req1) begin
            if (m_fav) eg1 = 1; else eg0 = 1;
          end else if (req0) eg0 = 1;
          else if (req1) eg1 = 1;
        end
        chk("m_gnt0", g0, eg0);
        chk("m_gnt1", g1, eg1);
        e_wren = 0; e_cs = 0;
        if (m_busy) begin
          e_addr = AW'(m_caddr); e_data = m_col; e_wren = 1; e_cs = 1;
          shadow[m_caddr] = m_col;
          m_caddr++; m_left--;
          if (m_left == 0) m_busy = 0;
        end else if (clr_req) begin
          m_busy = 1; m_left = MD; m_caddr = 0; m_col = clr_col;
        end else if (eg0 || eg1) begin
          sa = eg1 ? a1 : a0; sd = eg1 ? d1 : d0; sw = eg1 ? we1 : we0;
          inr = int'(sa) < MD;
          e_addr = sa; e_data = sd; e_wren = sw && inr; e_cs = inr;
          if (sw && inr) shadow[sa] = sd;
          if (!sw) sb.push_back('{cyc + 1 + RL, eg1, inr ? shadow[sa] : '0});
          m_fav = eg0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit id, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int gc);
    gc = -1;
    if (id) begin req1 = 1; we1 = we; a1 = a; d1 = d; end
    else    begin req0 = 1; we0 = we; a0 = a; d0 = d; end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((id ? g1 : g0) === 1'b1) begin
        gc = cyc;
        tick();
        break;
      end
      tick();
    end
    if (id) req1 = 0; else req0 = 0;
    if (gc < 0) chk("access_grant_timeout", 0, 1);
  endtask

  task automatic read_result(input bit id, input int gc, input logic [DW-1:0] exp,
                             input string nm);
    if (gc >= 0) begin
      while (cyc < gc + 1 + RL) tick();
      @(negedge clk);
      chk({nm, "_valid"}, id ? rv1 : rv0, 1);
      chk({nm, "_data"}, rdata, exp);
      tick();
    end
  endtask

  typedef struct {
    bit            r0, r1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    bit            eg0, eg1;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            ew, ecs;
  } vec_t;
  vec_t tbl[10];

  function automatic vec_t mk(bit r0, bit r1, bit w0, bit w1, int va0, int va1,
                              int vd0, int vd1, bit eg0, bit eg1, int ea, int ed,
                              bit ew, bit ecs);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = AW'(va0); v.a1 = AW'(va1); v.d0 = DW'(vd0); v.d1 = DW'(vd1);
    v.eg0 = eg0; v.eg1 = eg1; v.ea = AW'(ea); v.ed = DW'(ed); v.ew = ew; v.ecs = ecs;
    return v;
  endfunction

  int            gc, t0, gcyc, nbusy, nwr, badwr, k, np;
  int            gcs[4];
  int            pc[4];
  logic [DW-1:0] pd[4];
  logic [DW-1:0] b2b[4];
  bit            p0, p1;

  initial begin
    tbl[0] = mk(1,1, 1,1, 'h00010, 'h00020, 'h1FF, 'h055, 1,0, 'h00010, 'h1FF, 1,1);
    tbl[1] = mk(1,1, 1,1, 'h00030, 'h00020, 'h0AA, 'h055, 0,1, 'h00020, 'h055, 1,1);
    tbl[2] = mk(1,1, 1,0, 'h00030, 'h00010, 'h0AA, 'h000, 1,0, 'h00030, 'h0AA, 1,1);
    tbl[3] = mk(1,1, 0,0, 'h00020, 'h00010, 'h000, 'h000, 0,1, 'h00010, 'h000, 0,1);
    tbl[4] = mk(1,1, 0,1, 'h00020, 'h12BFF, 'h000, 'h1C3, 1,0, 'h00020, 'h000, 0,1);
    tbl[5] = mk(1,1, 1,1, 'h12C00, 'h12BFF, 'h123, 'h1C3, 0,1, 'h12BFF, 'h1C3, 1,1);
    tbl[6] = mk(1,0, 1,0, 'h12C00, 'h00000, 'h123, 'h000, 1,0, 'h12C00, 'h123, 0,0);
    tbl[7] = mk(1,0, 0,0, 'h00010, 'h00000, 'h000, 'h000, 1,0, 'h00010, 'h000, 0,1);
    tbl[8] = mk(0,0, 0,0, 'h00000, 'h00000, 'h000, 'h000, 0,0, 'h00010, 'h000, 0,0);
    tbl[9] = mk(0,1, 0,0, 'h00000, 'h00020, 'h000, 'h000, 0,1, 'h00020, 'h000, 0,1);
    b2b[0] = 9'h101; b2b[1] = 9'h0F0; b2b[2] = 9'h1A5; b2b[3] = 9'h033;

    rst = 1; clr_req = 0; clr_col = '0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    repeat (3) tick();
    rst = 0;

    // reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cs", cs, 0);
    chk("rst_wren", wren, 0);
    chk("rst_addr", oaddr, 0);
    chk("rst_data", odata, 0);
    chk("rst_rv0", rv0, 0);
    chk("rst_rv1", rv1, 0);
    tick();

    // arbitration vectors
    for (int i = 0; i < 10; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; we0 = tbl[i].w0; we1 = tbl[i].w1;
      a0 = tbl[i].a0; a1 = tbl[i].a1; d0 = tbl[i].d0; d1 = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt0", i), g0, tbl[i].eg0);
      chk($sformatf("vec%0d_gnt1", i), g1, tbl[i].eg1);
      tick();
      chk($sformatf("vec%0d_addr", i), oaddr, tbl[i].ea);
      chk($sformatf("vec%0d_data", i), odata, tbl[i].ed);
      chk($sformatf("vec%0d_wren", i), wren, tbl[i].ew);
      chk($sformatf("vec%0d_cs", i), cs, tbl[i].ecs);
    end
    req0 = 0; req1 = 0;
    repeat (6) tick();

    // req 1 reads back the colour written to 0x00010
    access(1, 0, AW'('h00010), '0, gc);
    read_result(1, gc, 9'h1FF, "rd_after_wr");

    // out-of-range read: no memory access, data returns as 0
    access(0, 0, AW'(MD), '0, gc);
    chk("oor_cs", cs, 0);
    chk("oor_wren", wren, 0);
    read_result(0, gc, '0, "oor_read");

    // back-to-back reads from req 0
    for (int i = 0; i < 4; i++) access(0, 1, AW'('h100 + i), b2b[i], gc);
    repeat (4) tick();
    k = 0; np = 0;
    req0 = 1; we0 = 0; a0 = AW'('h100);
    for (int c = 0; c < 60 && np < 4; c++) begin
      @(negedge clk);
      if (rv0 === 1'b1) begin pc[np] = cyc; pd[np] = rdata; np++; end
      if (k < 4 && g0 === 1'b1) begin gcs[k] = cyc; k++; end
      tick();
      if (k < 4) a0 = AW'('h100 + k); else req0 = 0;
    end
    req0 = 0;
    chk("b2b_grants", k, 4);
    chk("b2b_pulses", np, 4);
    if (k == 4 && np == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("b2b_gnt_cyc%0d", j), gcs[j], gcs[0] + j);
        chk($sformatf("b2b_rv_cyc%0d", j), pc[j], gcs[0] + 1 + RL + j);
        chk($sformatf("b2b_data%0d", j), pd[j], b2b[j]);
      end
    end
    repeat (4) tick();

    // reset during clear with two reads in flight
    req0 = 1; we0 = 0; a0 = AW'('h00010);
    tick();
    req0 = 0; req1 = 1; we1 = 0; a1 = AW'('h00020);
    tick();
    req1 = 0; clr_req = 1; clr_col = 9'h1F0;
    tick();
    clr_req = 0; rst = 1;
    @(negedge clk);
    chk("mid_clear_busy", busy, 1);
    tick();
    rst = 0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rv0", rv0, 0);
    chk("post_rst_rv1", rv1, 0);
    chk("post_rst_cs", cs, 0);
    chk("post_rst_wren", wren, 0);
    chk("post_rst_addr", oaddr, 0);
    chk("post_rst_data", odata, 0);
    chk("post_rst_rdata", rdata, 0);
    tick();
    repeat (4) tick();

    // randomized traffic
    p0 = 0; p1 = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; we0 = 1'($urandom_range(0, 1)); d0 = DW'($urandom);
        case ($urandom_range(0, 9))
          0: a0 = AW'(MD + int'($urandom_range(0, 100)));
          1: a0 = AW'(MD - 1 - int'($urandom_range(0, 3)));
          default: a0 = AW'($urandom_range(0, 63));
        endcase
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; we1 = 1'($urandom_range(0, 1)); d1 = DW'($urandom);
        case ($urandom_range(0, 9))
          0: a1 = AW'(MD + int'($urandom_range(0, 100)));
          1: a1 = AW'(MD - 1 - int'($urandom_range(0, 3)));
          default: a1 = AW'($urandom_range(0, 63));
        endcase
      end
      req0 = p0; req1 = p1;
      @(negedge clk);
      if (g0 === 1'b1) p0 = 0;
      if (g1 === 1'b1) p1 = 0;
      tick();
    end
    req0 = 0; req1 = 0; rst = 0;
    repeat (6) tick();

    // clear request wins over a simultaneous req 0 write
    clr_req = 1; clr_col = 9'h0E0;
    req0 = 1; we0 = 1; a0 = AW'('h00040); d0 = 9'h155;
    @(negedge clk);
    chk("clr_no_gnt0", g0, 0);
    t0 = cyc;
    tick();
    clr_req = 0;
    gcyc = -1; nbusy = 0; nwr = 0; badwr = 0;
    for (int c = 0; c < MD + 100; c++) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
      if (cs === 1'b1 && wren === 1'b1) begin
        if (int'(oaddr) != nwr || odata !== 9'h0E0) badwr++;
        nwr++;
      end
      if (g0 === 1'b1) begin gcyc = cyc; break; end
      tick();
    end
    tick();
    req0 = 0;
    chk("clr_busy_cycles", nbusy, MD);
    chk("clr_write_count", nwr, MD);
    chk("clr_write_seq_errs", badwr, 0);
    chk("clr_then_gnt0_cyc", gcyc, t0 + MD + 1);
    repeat (3) tick();
    access(1, 0, AW'('h00500), '0, gc);
    read_result(1, gc, 9'h0E0, "clr_fill");
    access(1, 0, AW'(MD - 1), '0, gc);
    read_result(1, gc, 9'h0E0, "clr_last");
    access(0, 0, AW'('h00040), '0, gc);
    read_result(0, gc, 9'h155, "post_clr_wr");
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1500000;
    n_err++;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected finish earlier", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
